// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit that owns the HI/LO register pair.
//   Multiplies with a shift-add loop and divides with a restoring loop.
//   Each operation takes WIDTH iterations. The pipeline stalls while busy=1.
//
//   Build option:
//     MDU_EARLY_TERM_EN - when defined, a multiply leaves RUN as soon as
//                         the remaining multiplier is zero.
//                         Divide latency does not change.
//
//   Ports:
//     clock       rising-edge clock
//     reset       asynchronous, active-high reset
//     start       request an operation (sampled only in IDLE)
//     op[1:0]     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     a, b        rs / rt operands
//     hi_we       MTHI strobe (IDLE only)
//     lo_we       MTLO strobe (IDLE only)
//     wd          MTHI/MTLO write data
//     busy        high while state is not IDLE
//     done        one-cycle pulse while hi/lo hold a fresh result
//     hi, lo      product {hi,lo}, or remainder (hi) / quotient (lo)
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | waiting for start; MTHI/MTLO writes accepted
//   PREP  | take operand magnitudes, record signs, load working regs
//   RUN   | one multiply or divide iteration per edge
//   FIN   | hi/lo valid, done=1; returns to IDLE on the next edge
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

`ifdef MDU_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PREP, RUN, FIN} state_t;

    state_t               state;
    logic [1:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     dvd;      // dividend shifts out; quotient bits shift in
    logic [WIDTH-1:0]     dvs;
    logic [WIDTH-1:0]     rem;
    logic [CW-1:0]        cnt;
    logic                 res_neg;
    logic                 rem_neg;
    logic                 div_zero;

    // Operand magnitudes for PREP. Only signed ops (op[0]=0) are corrected.
    logic                 neg_a;
    logic                 neg_b;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;

    // Iteration step and the final sign-corrected results.
    logic [2*WIDTH-1:0]   prod_step;
    logic [WIDTH:0]       rem_sh;
    logic [WIDTH:0]       rem_sub;
    logic                 rem_ge;
    logic [WIDTH-1:0]     rem_step;
    logic [WIDTH-1:0]     quo_step;
    logic                 early_stop;
    logic [2*WIDTH-1:0]   prod_fin;
    logic [2*WIDTH-1:0]   prod_res;
    logic [WIDTH-1:0]     quo_res;
    logic [WIDTH-1:0]     rem_res;

    always_comb begin
        neg_a      = 1'b0;
        neg_b      = 1'b0;
        mag_a      = a_r;
        mag_b      = b_r;
        prod_step  = prod;
        rem_sh     = '0;
        rem_sub    = '0;
        rem_ge     = 1'b0;
        rem_step   = '0;
        quo_step   = '0;
        early_stop = 1'b0;
        prod_fin   = '0;
        prod_res   = '0;
        quo_res    = '0;
        rem_res    = '0;

        neg_a = ~op_r[0] & a_r[WIDTH-1];
        neg_b = ~op_r[0] & b_r[WIDTH-1];
        mag_a = neg_a ? -a_r : a_r;
        mag_b = neg_b ? -b_r : b_r;

        if (mplier[0]) begin
            prod_step = prod + mcand;
        end

        rem_sh   = {rem, dvd[WIDTH-1]};
        rem_sub  = rem_sh - {1'b0, dvs};
        rem_ge   = (rem_sh >= {1'b0, dvs});
        rem_step = rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_step = {dvd[WIDTH-2:0], rem_ge};

        // A zero multiplier means every remaining step adds nothing.
        early_stop = EARLY_TERM && !op_r[1] && (mplier == '0);

        prod_fin = early_stop ? prod : prod_step;
        prod_res = res_neg ? -prod_fin : prod_fin;

        // The magnitude of 0x80..0 / -1 is 0x80..0 with res_neg=0.
        // It therefore comes out as 0x80..0 with no special case.
        if (!div_zero) begin
            quo_res = res_neg ? -quo_step : quo_step;
            rem_res = rem_neg ? -rem_step : rem_step;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            op_r     <= '0;
            a_r      <= '0;
            b_r      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wd;
                    if (lo_we) lo <= wd;
                    if (start) begin
                        op_r  <= op;
                        a_r   <= a;
                        b_r   <= b;
                        busy  <= 1'b1;
                        state <= PREP;
                    end
                end
                PREP: begin
                    mcand    <= {{WIDTH{1'b0}}, mag_a};
                    mplier   <= mag_b;
                    prod     <= '0;
                    dvd      <= mag_a;
                    dvs      <= mag_b;
                    rem      <= '0;
                    cnt      <= CNT_LOAD;
                    res_neg  <= neg_a ^ neg_b;
                    rem_neg  <= neg_a;
                    div_zero <= (b_r == '0);
                    state    <= RUN;
                end
                RUN: begin
                    if (!early_stop) begin
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        prod   <= prod_step;
                        rem    <= rem_step;
                        dvd    <= quo_step;
                        cnt    <= cnt - 1'b1;
                    end
                    if (early_stop || cnt == '0) begin
                        if (op_r[1]) begin
                            hi <= rem_res;
                            lo <= quo_res;
                        end else begin
                            hi <= prod_res[2*WIDTH-1:WIDTH];
                            lo <= prod_res[WIDTH-1:0];
                        end
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
